// File: rtl/svm_stream_classifier.sv
// Streaming linear-SVM classifier: serial features are MAC'd against loadable weights,
// a loadable bias is added, and the saturated score is thresholded to a 1-bit class.
module svm_stream_classifier #(
  parameter  int N_FEAT = 4,
  parameter  int FEAT_W = 16,
  parameter  int WGT_W  = 10,
  parameter  int BIAS_W = 22,
  parameter  int ACC_W  = 28,
  localparam int ADDR_W = $clog2(N_FEAT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we_i,
  input  logic [ADDR_W-1:0]        cfg_addr_i,
  input  logic [BIAS_W-1:0]        cfg_data_i,
  input  logic                     feat_valid_i,
  output logic                     feat_ready_o,
  input  logic [FEAT_W-1:0]        feat_data_i,
  input  logic                     feat_last_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     res_class_o,
  output logic signed [ACC_W-1:0]  res_score_o,
  output logic                     res_err_o,
  output logic                     busy_o
);

  localparam int PROD_W = FEAT_W + WGT_W + 1;
  localparam int MAX_AB = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam int MAX_W  = (MAX_AB > BIAS_W) ? MAX_AB : BIAS_W;
  localparam int SUM_W  = MAX_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_RES} state_e;

  state_e                    state_q, state_d;
  logic signed [WGT_W-1:0]   wgt_q [N_FEAT];
  logic signed [BIAS_W-1:0]  bias_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic                      err_q, err_d;
  logic signed [ACC_W-1:0]   score_q, score_d;
  logic                      class_q, class_d;
  logic                      rerr_q, rerr_d;

  logic                      feat_hs;
  logic                      last_idx;
  logic signed [WGT_W-1:0]   wgt_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   mac_sum;
  logic signed [SUM_W-1:0]   bias_sum;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[ACC_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[ACC_W-1:0];
    else                  return s[ACC_W-1:0];
  endfunction

  assign feat_ready_o = (state_q == S_IDLE) || (state_q == S_ACC);
  assign res_valid_o  = (state_q == S_RES);
  assign busy_o       = (state_q != S_IDLE);
  assign res_class_o  = class_q;
  assign res_score_o  = score_q;
  assign res_err_o    = rerr_q;

  assign feat_hs  = feat_valid_i & feat_ready_o;
  assign last_idx = (idx_q == ADDR_W'(N_FEAT - 1));

  always_comb begin
    wgt_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx_q == ADDR_W'(i)) wgt_sel = wgt_q[i];
    end
  end

  // Feature is unsigned, so a zero MSB is prepended before the signed multiply.
  assign prod     = PROD_W'($signed({1'b0, feat_data_i})) * PROD_W'(wgt_sel);
  assign mac_sum  = SUM_W'(acc_q) + SUM_W'(prod);
  assign bias_sum = SUM_W'(acc_q) + SUM_W'(bias_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    err_d   = err_q;
    score_d = score_q;
    class_d = class_q;
    rerr_d  = rerr_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (feat_hs) begin
          acc_d = sat(mac_sum);
          idx_d = idx_q + ADDR_W'(1);
          if (feat_last_i || last_idx) begin
            state_d = S_BIAS;
            err_d   = ~(feat_last_i & last_idx);
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_BIAS: begin
        score_d = sat(bias_sum);
        class_d = ~score_d[ACC_W-1];
        rerr_d  = err_q;
        state_d = S_RES;
      end
      S_RES: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      score_q <= '0;
      class_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      score_q <= score_d;
      class_q <= class_d;
      rerr_q  <= rerr_d;
    end
  end

  // Coefficients only change between frames so a frame never mixes old and new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '0;
      for (int i = 0; i < N_FEAT; i++) wgt_q[i] <= '0;
    end else if (cfg_we_i && (state_q == S_IDLE)) begin
      if (cfg_addr_i == ADDR_W'(N_FEAT)) begin
        bias_q <= cfg_data_i;
      end else begin
        for (int i = 0; i < N_FEAT; i++) begin
          if (cfg_addr_i == ADDR_W'(i)) wgt_q[i] <= cfg_data_i[WGT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_svm_stream_classifier.sv
// Self-checking bench for svm_stream_classifier: a default (ACC_W=28) and a narrow (ACC_W=20)
// instance share stimulus; results come from a table of known vectors and an arithmetic model.
module tb_svm_stream_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [21:0] cfg_data = '0;
  logic        feat_valid = 1'b0;
  logic [15:0] feat_data = '0;
  logic        feat_last = 1'b0;
  logic        res_ready = 1'b0;

  logic        feat_ready, res_valid, res_class, res_err, busy;
  logic [27:0] res_score;
  logic        feat_ready20, res_valid20, res_class20, res_err20, busy20;
  logic [19:0] res_score20;

  int assertCount = 0;
  int failCount   = 0;

  int curW [4];
  int curBias;
  int curF [4];

  typedef struct packed {
    logic [3:0][9:0]  w;
    int               bias;
    logic [3:0][15:0] f;
    int               nb;
    logic             lastFinal;
    int               expScore;
    logic             expClass;
    logic             expErr;
    int               expScore20;
  } vec_t;

  vec_t vecs [8];

  svm_stream_classifier dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .feat_valid_i(feat_valid), .feat_ready_o(feat_ready),
    .feat_data_i(feat_data), .feat_last_i(feat_last),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_class_o(res_class), .res_score_o(res_score),
    .res_err_o(res_err), .busy_o(busy)
  );

  svm_stream_classifier #(.ACC_W(20)) dut20 (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .feat_valid_i(feat_valid), .feat_ready_o(feat_ready20),
    .feat_data_i(feat_data), .feat_last_i(feat_last),
    .res_valid_o(res_valid20), .res_ready_i(res_ready),
    .res_class_o(res_class20), .res_score_o(res_score20),
    .res_err_o(res_err20), .busy_o(busy20)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint clampAcc(input longint v, input int accw);
    longint mx = (longint'(1) <<< (accw - 1)) - 1;
    longint mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference: saturating dot product over the beats actually sent, then bias.
  function automatic longint modelScore(input int accw, input int nb);
    longint acc = 0;
    for (int i = 0; i < nb; i++) acc = clampAcc(acc + longint'(curF[i]) * longint'(curW[i]), accw);
    return clampAcc(acc + longint'(curBias), accw);
  endfunction

  function automatic vec_t mkVec(input int w0, input int w1, input int w2, input int w3, input int b,
                                 input int f0, input int f1, input int f2, input int f3,
                                 input int nb, input logic lf, input int es, input logic ec,
                                 input logic ee, input int es20);
    vec_t v;
    v.w[0] = 10'(w0); v.w[1] = 10'(w1); v.w[2] = 10'(w2); v.w[3] = 10'(w3);
    v.bias = b;
    v.f[0] = 16'(f0); v.f[1] = 16'(f1); v.f[2] = 16'(f2); v.f[3] = 16'(f3);
    v.nb = nb; v.lastFinal = lf;
    v.expScore = es; v.expClass = ec; v.expErr = ee; v.expScore20 = es20;
    return v;
  endfunction

  task automatic loadConfig();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 3'(i);
      cfg_data = (i < 4) ? 22'(curW[i]) : 22'(curBias);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Sends curF[0..nb-1] and checks that res_valid rises exactly two edges after the final beat.
  task automatic applyStimulus(input string name, input int nb, input logic lastFinal);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      feat_valid = 1'b1;
      feat_data  = 16'(curF[b]);
      feat_last  = lastFinal && (b == nb - 1);
      @(posedge clk);
      #1;
    end
    checkOutput({name, " res_valid t+1"}, longint'(res_valid), 0);
    @(negedge clk);
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, " res_valid t+2"}, longint'(res_valid), 1);
    checkOutput({name, " res_valid20 t+2"}, longint'(res_valid20), 1);
  endtask

  task automatic checkResult(input string name, input longint es, input logic ee, input longint es20);
    checkOutput({name, " score"}, longint'($signed(res_score)), es);
    checkOutput({name, " class"}, longint'(res_class), (es >= 0) ? 1 : 0);
    checkOutput({name, " err"}, longint'(res_err), longint'(ee));
    checkOutput({name, " score20"}, longint'($signed(res_score20)), es20);
    checkOutput({name, " class20"}, longint'(res_class20), (es20 >= 0) ? 1 : 0);
    checkOutput({name, " err20"}, longint'(res_err20), longint'(ee));
  endtask

  task automatic acceptResult(input string name);
    int waited = 0;
    while (!res_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!res_valid) checkOutput({name, " result timeout"}, longint'(res_valid), 1);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, " res_valid after accept"}, longint'(res_valid), 0);
    checkOutput({name, " busy after accept"}, longint'(busy), 0);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = mkVec(-37, -1, -233, -423, 131072, 100, 200, 50, 10, 4, 1'b1, 111292, 1'b1, 1'b0, 111292);
    vecs[1] = mkVec(-37, -1, -233, -423, 131072, 1000, 0, 300, 200, 4, 1'b1, -60428, 1'b0, 1'b0, -60428);
    vecs[2] = mkVec(511, 511, 511, 511, 0, 65535, 65535, 65535, 65535, 4, 1'b1, 133953540, 1'b1, 1'b0, 524287);
    vecs[3] = mkVec(-512, -512, -512, -512, 0, 65535, 65535, 65535, 65535, 4, 1'b1, -134215680, 1'b0, 1'b0, -524288);
    vecs[4] = mkVec(0, 0, 0, 0, 0, 5, 6, 7, 8, 4, 1'b1, 0, 1'b1, 1'b0, 0);
    vecs[5] = mkVec(0, 0, 0, 0, 0, 9, 9, 0, 0, 2, 1'b1, 0, 1'b1, 1'b1, 0);
    vecs[6] = mkVec(0, 0, 0, 0, 0, 1, 2, 3, 4, 4, 1'b0, 0, 1'b1, 1'b1, 0);
    vecs[7] = mkVec(3, 5, 7, 11, 0, 10, 20, 0, 0, 2, 1'b1, 130, 1'b1, 1'b1, 130);

    #2 rst = 1'b1;
    #20;
    checkOutput("reset feat_ready", longint'(feat_ready), 1);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset res_valid", longint'(res_valid), 0);
    checkOutput("reset res_score", longint'($signed(res_score)), 0);
    checkOutput("reset res_class", longint'(res_class), 0);
    checkOutput("reset res_err", longint'(res_err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        curW[i] = int'($signed(vecs[k].w[i]));
        curF[i] = int'(vecs[k].f[i]);
      end
      curBias = vecs[k].bias;
      loadConfig();
      applyStimulus($sformatf("vec%0d", k), vecs[k].nb, vecs[k].lastFinal);
      checkResult($sformatf("vec%0d", k), longint'(vecs[k].expScore), vecs[k].expErr,
                  longint'(vecs[k].expScore20));
      checkOutput($sformatf("vec%0d class const", k), longint'(res_class), longint'(vecs[k].expClass));
      acceptResult($sformatf("vec%0d", k));
    end

    // Backpressure: result held, input stalled, config writes ignored while busy.
    curW = '{-37, -1, -233, -423};
    curBias = 131072;
    curF = '{100, 200, 50, 10};
    loadConfig();
    applyStimulus("hold", 4, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 3'(c);
      cfg_data = 22'd7;
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d score", c), longint'($signed(res_score)), 111292);
      checkOutput($sformatf("hold%0d res_valid", c), longint'(res_valid), 1);
      checkOutput($sformatf("hold%0d feat_ready", c), longint'(feat_ready), 0);
      checkOutput($sformatf("hold%0d busy", c), longint'(busy), 1);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    acceptResult("hold");
    applyStimulus("after hold", 4, 1'b1);
    checkResult("after hold", 111292, 1'b0, 111292);
    acceptResult("after hold");

    // Out-of-range config addresses must not disturb weights or bias.
    curW = '{2, 2, 2, 2};
    curBias = 10;
    curF = '{1, 1, 1, 1};
    loadConfig();
    for (int a = 5; a < 8; a++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 3'(a);
      cfg_data = 22'd999;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    applyStimulus("bad addr", 4, 1'b1);
    checkResult("bad addr", 18, 1'b0, 18);
    acceptResult("bad addr");

    // Reset after two beats: previous held score (18) must vanish immediately.
    curW = '{1, 2, 3, 4};
    curBias = 100;
    curF = '{7, 7, 7, 7};
    loadConfig();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      feat_valid = 1'b1;
      feat_data  = 16'(curF[b]);
      feat_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    feat_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midreset res_valid", longint'(res_valid), 0);
    checkOutput("midreset res_score", longint'($signed(res_score)), 0);
    checkOutput("midreset res_class", longint'(res_class), 0);
    checkOutput("midreset res_err", longint'(res_err), 0);
    checkOutput("midreset busy", longint'(busy), 0);
    checkOutput("midreset feat_ready", longint'(feat_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    curF = '{1234, 40000, 99, 65535};
    applyStimulus("post reset", 4, 1'b1);
    checkResult("post reset", 0, 1'b0, 0);
    acceptResult("post reset");

    // Randomized frames against the arithmetic model.
    for (int r = 0; r < 25; r++) begin
      int nb;
      logic lf;
      logic expErr;
      if (r == 0 || $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) curW[i] = int'($urandom_range(0, 1023)) - 512;
        curBias = int'($urandom_range(0, 4194303)) - 2097152;
        loadConfig();
      end
      for (int i = 0; i < 4; i++) curF[i] = int'($urandom_range(0, 65535));
      nb = int'($urandom_range(2, 4));
      lf = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      expErr = !(lf && nb == 4);
      applyStimulus($sformatf("rand%0d", r), nb, lf);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checkResult($sformatf("rand%0d", r), modelScore(28, nb), expErr, modelScore(20, nb));
      acceptResult($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
